// File: rtl/pipe_stage3_reduce.sv
// Third pipeline stage: per-vector MAC / sum-of-squares / max reduction or element-wise multiply.
// Optional feature macro PIPE_STAGE3_SAT_EN: saturating accumulation with sticky overflow_o.
module pipe_stage3_reduce #(
   parameter int DATA_W = 16,
   parameter int ACC_W  = 40,
   parameter int CNT_W  = 12
) (
   input  logic                     CLK_i,
   input  logic                     RST_i,
   input  logic                     stall_i,
   input  logic                     valid_i,
   input  logic signed [DATA_W-1:0] operand1_i,
   input  logic signed [DATA_W-1:0] operand2_i,
   input  logic [1:0]               mode_i,
   input  logic                     stage_boundary_i,
   output logic                     stall_o,
   output logic signed [ACC_W-1:0]  result_o,
   output logic                     result_valid_o,
   output logic [CNT_W-1:0]         count_o,
   output logic                     busy_o,
   output logic                     overflow_o,
   output logic                     mode_err_o
);
   localparam int PW = 2 * DATA_W;

   typedef enum logic [1:0] {MODE_MAC = 2'b00, MODE_MUL = 2'b01,
                             MODE_SSQ = 2'b10, MODE_MAX = 2'b11} mode_t;
   typedef enum logic {IDLE, ACCUM} state_t;

   state_t state, state_nx;
   mode_t  mode_lat, mode_nx, mode_eff;
   logic   err_nx;

   logic signed [PW-1:0]    a_x, b_x, prod_nx;
   logic                    v1, bnd1, first1, v2;
   mode_t                   mode1;
   logic signed [PW-1:0]    p1;
   logic signed [ACC_W-1:0] p_ext, acc, acc_nx, add_res;
   logic [CNT_W-1:0]        cnt, cnt_nx;

   assign stall_o = stall_i;
   assign busy_o  = (state == ACCUM) | v1 | v2;

   // Mode is decided at acceptance: live mode_i on a vector's first element, latched copy afterwards.
   always_comb begin
      state_nx = state;
      mode_nx  = mode_lat;
      mode_eff = (state == ACCUM) ? mode_lat : mode_t'(mode_i);
      err_nx   = 1'b0;
      if (valid_i) begin
         if (state == IDLE) begin
            mode_nx = mode_t'(mode_i);
            if (!stage_boundary_i) state_nx = ACCUM;
         end else begin
            err_nx = (mode_t'(mode_i) != mode_lat);
            if (stage_boundary_i) state_nx = IDLE;
         end
      end
   end

   always_ff @(posedge CLK_i) begin
      if (RST_i) begin
         state      <= IDLE;
         mode_lat   <= MODE_MAC;
         mode_err_o <= 1'b0;
      end else if (!stall_i) begin
         state      <= state_nx;
         mode_lat   <= mode_nx;
         mode_err_o <= err_nx;
      end
   end

   assign a_x = PW'(operand1_i);
   assign b_x = PW'(operand2_i);

   always_comb begin
      prod_nx = a_x * b_x;
      case (mode_eff)
         MODE_SSQ: prod_nx = a_x * a_x;
         MODE_MAX: prod_nx = a_x;
         default:  prod_nx = a_x * b_x;
      endcase
   end

   always_ff @(posedge CLK_i) begin
      if (RST_i) begin
         v1     <= 1'b0;
         bnd1   <= 1'b0;
         first1 <= 1'b0;
         mode1  <= MODE_MAC;
         p1     <= '0;
      end else if (!stall_i) begin
         v1     <= valid_i;
         bnd1   <= stage_boundary_i;
         first1 <= (state == IDLE);
         mode1  <= mode_eff;
         p1     <= prod_nx;
      end
   end

   assign p_ext = ACC_W'(p1);

`ifdef PIPE_STAGE3_SAT_EN
   localparam logic signed [ACC_W-1:0] ACC_MAX = {1'b0, {(ACC_W-1){1'b1}}};
   localparam logic signed [ACC_W-1:0] ACC_MIN = {1'b1, {(ACC_W-1){1'b0}}};
   logic signed [ACC_W:0] sum_w;
   logic                  add_clip, ovf;

   // One guard bit: a clip is a disagreement between the guard and the result sign.
   assign sum_w = {acc[ACC_W-1], acc} + {p_ext[ACC_W-1], p_ext};

   always_comb begin
      add_res  = sum_w[ACC_W-1:0];
      add_clip = 1'b0;
      if (sum_w[ACC_W] != sum_w[ACC_W-1]) begin
         add_clip = 1'b1;
         add_res  = sum_w[ACC_W] ? ACC_MIN : ACC_MAX;
      end
   end

   always_ff @(posedge CLK_i) begin
      if (RST_i) begin
         ovf <= 1'b0;
      end else if (!stall_i && v1 && mode1 != MODE_MUL) begin
         if (first1)                            ovf <= 1'b0;
         else if (mode1 != MODE_MAX && add_clip) ovf <= 1'b1;
      end
   end

   assign overflow_o = ovf;
`else
   assign add_res    = acc + p_ext;
   assign overflow_o = 1'b0;
`endif

   always_comb begin
      cnt_nx = first1 ? CNT_W'(1) : ((&cnt) ? cnt : cnt + CNT_W'(1));
      acc_nx = acc;
      if (first1)                 acc_nx = p_ext;
      else if (mode1 == MODE_MAX) acc_nx = (p_ext > acc) ? p_ext : acc;
      else                        acc_nx = add_res;
   end

   always_ff @(posedge CLK_i) begin
      if (RST_i) begin
         v2             <= 1'b0;
         acc            <= '0;
         cnt            <= '0;
         result_o       <= '0;
         count_o        <= '0;
         result_valid_o <= 1'b0;
      end else if (!stall_i) begin
         v2             <= v1;
         result_valid_o <= 1'b0;
         if (v1) begin
            if (mode1 == MODE_MUL) begin
               result_o       <= p_ext;
               count_o        <= CNT_W'(1);
               result_valid_o <= 1'b1;
            end else begin
               acc <= acc_nx;
               cnt <= cnt_nx;
               if (bnd1) begin
                  result_o       <= acc_nx;
                  count_o        <= cnt_nx;
                  result_valid_o <= 1'b1;
               end
            end
         end
      end
   end
endmodule
